alu_issue_queue: RTL and testbench
==================================

// Module: alu_issue_queue
// PURPOSE
//  Command stage wrapped around the 5-bit combinational ALU (AND/ADD/OR/XOR).
//  - Buffers {op, A, B} commands in a small FIFO.
//  - Drives the ALU operand and select inputs from the FIFO head.
//  - Registers the ALU result into an output slot with a valid/ready handshake.
//  Decouples upstream producers from downstream consumers; one op retires per clock at most.
// PARAMETERS
//  WIDTH  5  operand/result width; must match the ALU instance
//  DEPTH  4  command FIFO entries; power of two, >=2
// PORTS
//  clk          in   1                  single clock, all state on rising edge
//  rst_n        in   1                  synchronous reset, active-low
//  flush        in   1                  synchronous clear of FIFO and result slot
//  cmd_valid    in   1                  upstream command valid
//  cmd_ready    out  1                  FIFO can accept (= !full)
//  cmd_op       in   2                  00 AND, 01 ADD, 10 OR, 11 XOR
//  cmd_a        in   WIDTH              operand A
//  cmd_b        in   WIDTH              operand B
//  alu_a        out  WIDTH              to ALU InA: head operand A, 0 when empty
//  alu_b        out  WIDTH              to ALU InB: head operand B, 0 when empty
//  alu_sel      out  2                  to ALU select: head op, 0 when empty
//  alu_result   in   WIDTH              from ALU Out (combinational)
//  res_valid    out  1                  result slot holds a result
//  res_ready    in   1                  downstream accepts result
//  res_data     out  WIDTH              registered ALU result
//  res_op       out  2                  op that produced res_data
//  res_zero     out  1                  res_data == 0, registered with res_data
//  count        out  $clog2(DEPTH+1)    FIFO occupancy
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): FIFO empty, count=0, cmd_ready=1.
//    res_valid=0, res_data=0, res_op=0, res_zero=0. Reset mid-operation discards all state.
//  - push = cmd_valid & cmd_ready. Writes {op,a,b} at the write pointer; pointer wraps modulo DEPTH.
//  - pop = !empty & (!res_valid | res_ready). Captures alu_result and head op into the slot.
//    Sets res_zero and res_valid=1. Advances the read pointer (wraps modulo DEPTH).
//  - Slot drain: res_valid & res_ready & !pop -> res_valid=0. res_data/res_op/res_zero hold their last value.
//  - Push and pop in the same cycle: count unchanged. A full FIFO does NOT accept on a pop cycle.
//    cmd_ready depends only on the registered count.
//  - Latency: a command pushed at edge N into an empty FIFO with a free slot gives res_valid=1 after edge N+1.
//  - Throughput: one result per cycle while res_ready=1 and the FIFO is non-empty.
//  - Backpressure: with res_valid=1 and res_ready=0, the slot and all res_* outputs hold stable. No pop occurs.
//  - Arithmetic: ADD is modulo 2^WIDTH; the ALU carry is not used.
//  - alu_a/alu_b/alu_sel are combinational from the head entry; the ALU result is sampled in the same cycle.
//  - flush: same effect as reset on FIFO and slot. Priority over push/pop in that cycle.
//    A command offered in that cycle is dropped.
//  - Priority: rst_n > flush > push/pop.
//  - Invariant: count never exceeds DEPTH and never underflows.
// TESTING
//  - Reset: hold rst_n=0 two cycles -> count=0, cmd_ready=1, res_valid=0, res_data=0.
//  - ADD wrap: push op=01 a=20 b=15, res_ready=1 -> one cycle later res_valid=1, res_data=3, res_op=01, res_zero=0.
//  - Mixed ops: push AND 10110&01101, OR 10000|00011, XOR 5^5 back-to-back, res_ready=1.
//    -> results 00100, 10011, 00000 on consecutive cycles; res_zero=1 on the third only.
//  - Full/backpressure: res_ready=0, push 5 commands -> slot holds cmd1.
//    count reaches 4, cmd_ready=0, 6th push refused, outputs stable.
//    Then res_ready=1 -> 5 results in order, one per cycle.
//  - Flush mid-stream: 3 queued + valid slot, flush=1 with cmd_valid=1.
//    -> next cycle count=0, res_valid=0, offered command absent from output.
//  - Pointer wrap: stream 10 commands with res_ready toggling every cycle -> all 10 results in order, none lost or duplicated.

Source files
------------

// File: rtl/alu_issue_queue.sv
// -----------------------------------------------------------------------------
// alu_issue_queue
//   Command stage around an external combinational ALU (AND/ADD/OR/XOR).
//   Commands {op, a, b} are buffered in a small FIFO. The FIFO head drives the
//   ALU inputs, and the ALU result is registered into a single output slot
//   with a valid/ready handshake. At most one operation retires per clock.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 synchronous clear of FIFO and result slot
//   cmd_valid/cmd_ready   upstream handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_a, cmd_b  command: 00 AND, 01 ADD, 10 OR, 11 XOR
//   alu_a, alu_b, alu_sel head-of-FIFO operands/select to the ALU (0 if empty)
//   alu_result            combinational ALU output
//   res_valid/res_ready   downstream handshake for the result slot
//   res_data, res_op      registered result and the op that produced it
//   res_zero              res_data == 0, registered with res_data
//   count                 FIFO occupancy
// -----------------------------------------------------------------------------
module alu_issue_queue #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [1:0]                 cmd_op,
   input  logic [WIDTH-1:0]           cmd_a,
   input  logic [WIDTH-1:0]           cmd_b,
   output logic [WIDTH-1:0]           alu_a,
   output logic [WIDTH-1:0]           alu_b,
   output logic [1:0]                 alu_sel,
   input  logic [WIDTH-1:0]           alu_result,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [WIDTH-1:0]           res_data,
   output logic [1:0]                 res_op,
   output logic                       res_zero,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   // FIFO storage; the head must be readable combinationally, so it lives in flops
   logic [1:0]       op_q [DEPTH];
   logic [WIDTH-1:0] a_q  [DEPTH];
   logic [WIDTH-1:0] b_q  [DEPTH];
   logic [1:0]       op_d [DEPTH];
   logic [WIDTH-1:0] a_d  [DEPTH];
   logic [WIDTH-1:0] b_d  [DEPTH];

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic [1:0]       res_op_q, res_op_d;
   logic             res_zero_q, res_zero_d;

   logic empty;
   logic full;
   logic push;
   logic pop;
   logic push_en;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // cmd_ready looks only at the registered count: a full FIFO refuses even on a pop cycle
   assign push    = cmd_valid & ~full;
   assign pop     = ~empty & (~res_valid_q | res_ready);
   assign push_en = push & ~flush;

   assign alu_a   = empty ? '0 : a_q[rd_ptr_q];
   assign alu_b   = empty ? '0 : b_q[rd_ptr_q];
   assign alu_sel = empty ? 2'b00 : op_q[rd_ptr_q];

   // Per-entry write logic
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_comb begin
         op_d[gi] = op_q[gi];
         a_d[gi]  = a_q[gi];
         b_d[gi]  = b_q[gi];
         if (push_en && (wr_ptr_q == PW'(gi))) begin
            op_d[gi] = cmd_op;
            a_d[gi]  = cmd_a;
            b_d[gi]  = cmd_b;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            op_q[gi] <= 2'b00;
            a_q[gi]  <= '0;
            b_q[gi]  <= '0;
         end else begin
            op_q[gi] <= op_d[gi];
            a_q[gi]  <= a_d[gi];
            b_q[gi]  <= b_d[gi];
         end
      end
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_op_d    = res_op_q;
      res_zero_d  = res_zero_q;

      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         res_valid_d = 1'b0;
         res_data_d  = '0;
         res_op_d    = 2'b00;
         res_zero_d  = 1'b0;
      end else begin
         // DEPTH is a power of two, so pointers wrap by natural overflow
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            res_valid_d = 1'b1;
            res_data_d  = alu_result;
            res_op_d    = alu_sel;
            res_zero_d  = (alu_result == '0);
         end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_op_q    <= 2'b00;
         res_zero_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_op_q    <= res_op_d;
         res_zero_q  <= res_zero_d;
      end
   end

   assign cmd_ready = ~full;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_op    = res_op_q;
   assign res_zero  = res_zero_q;
   assign count     = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_queue
//   Directed bench for alu_issue_queue. A combinational ALU model is attached
//   to the alu_* ports. Expected results (hand computed) are queued when a
//   command is accepted; a monitor pops and compares on every result handshake.
// -----------------------------------------------------------------------------
module tb_alu_issue_queue;

   localparam int W = 5;
   localparam int D = 4;

   typedef struct packed {
      logic [W-1:0] data;
      logic [1:0]   op;
      logic         zero;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_a;
   logic [W-1:0] cmd_b;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [1:0]   alu_sel;
   logic [W-1:0] alu_result;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_data;
   logic [1:0]   res_op;
   logic         res_zero;
   logic [2:0]   count;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   // External 5-bit ALU
   always_comb begin
      alu_result = '0;
      case (alu_sel)
         2'b00: alu_result = alu_a & alu_b;
         2'b01: alu_result = W'(alu_a + alu_b);
         2'b10: alu_result = alu_a | alu_b;
         2'b11: alu_result = alu_a ^ alu_b;
         default: alu_result = '0;
      endcase
   end

   alu_issue_queue #(.WIDTH(W), .DEPTH(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_op     (res_op),
      .res_zero   (res_zero),
      .count      (count)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Called just after a rising edge; returns just after the next rising edge
   task automatic push_cmd(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] ed, input logic ez, output bit acc);
      exp_t e;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      @(negedge clk);
      acc = cmd_ready && !flush && rst_n;
      if (acc) begin
         e.data = ed;
         e.op   = op;
         e.zero = ez;
         exp_q.push_back(e);
      end
      $display("push op=%0d a=%0d b=%0d accepted=%0d", op, a, b, acc);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic push_retry(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] ed, input logic ez);
      bit acc;
      int tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
         push_cmd(op, a, b, ed, ez, acc);
         tries++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL push_retry_timeout: got not accepted required accepted");
      end
   endtask

   // Monitor: one result transfer per edge where res_valid & res_ready
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready && !flush) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got data=%0d required none", res_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("result data=%0d op=%0d zero=%0d (expected %0d/%0d/%0d)",
                     res_data, res_op, res_zero, e.data, e.op, e.zero);
            chk("res_data", int'(res_data), int'(e.data));
            chk("res_op",   int'(res_op),   int'(e.op));
            chk("res_zero", int'(res_zero), int'(e.zero));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Pointer-wrap stream: op, a, b, expected result, expected zero
   logic [1:0]   wop [10] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1};
   logic [W-1:0] wa  [10] = '{5'd10, 5'd25, 5'd31, 5'd4, 5'd21, 5'd16, 5'd12, 5'd1, 5'd30, 5'd7};
   logic [W-1:0] wb  [10] = '{5'd5, 5'd10, 5'd18, 5'd8, 5'd10, 5'd16, 5'd3, 5'd2, 5'd15, 5'd9};
   logic [W-1:0] wr  [10] = '{5'd15, 5'd3, 5'd18, 5'd12, 5'd31, 5'd0, 5'd0, 5'd3, 5'd17, 5'd16};
   logic         wz  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      bit acc;
      bit done;
      rst_n     = 1'b0;
      flush     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_a     = '0;
      cmd_b     = '0;
      res_ready = 1'b0;

      // ---------------- reset ----------------
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_count",     int'(count),     0);
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_res_data",  int'(res_data),  0);
      chk("rst_res_op",    int'(res_op),    0);
      chk("rst_res_zero",  int'(res_zero),  0);
      chk("rst_alu_sel",   int'(alu_sel),   0);
      chk("rst_alu_a",     int'(alu_a),     0);
      @(posedge clk);
      #1;

      // ---------------- ADD wrap + latency ----------------
      res_ready = 1'b1;
      push_cmd(2'b01, 5'd20, 5'd15, 5'd3, 1'b0, acc);
      @(negedge clk);
      chk("lat_valid_early", int'(res_valid), 0);
      chk("lat_count",       int'(count),     1);
      chk("lat_alu_a",       int'(alu_a),     20);
      chk("lat_alu_sel",     int'(alu_sel),   1);
      @(negedge clk);
      chk("lat_valid",       int'(res_valid), 1);
      chk("add_wrap_data",   int'(res_data),  3);
      @(posedge clk);
      #1;

      // ---------------- mixed ops back-to-back ----------------
      push_cmd(2'b00, 5'b10110, 5'b01101, 5'b00100, 1'b0, acc);
      push_cmd(2'b10, 5'b10000, 5'b00011, 5'b10011, 1'b0, acc);
      push_cmd(2'b11, 5'd5,     5'd5,     5'b00000, 1'b1, acc);
      @(negedge clk);
      chk("mix_second_data", int'(res_data), 19);
      chk("mix_second_zero", int'(res_zero), 0);
      @(negedge clk);
      chk("mix_third_data",  int'(res_data), 0);
      chk("mix_third_zero",  int'(res_zero), 1);
      repeat (2) @(posedge clk);
      #1;
      chk("mix_drained", exp_q.size(), 0);

      // ---------------- full / backpressure ----------------
      res_ready = 1'b0;
      push_cmd(2'b01, 5'd1,  5'd1,  5'd2,  1'b0, acc); chk("bp_acc1", int'(acc), 1);
      push_cmd(2'b00, 5'd31, 5'd7,  5'd7,  1'b0, acc); chk("bp_acc2", int'(acc), 1);
      push_cmd(2'b10, 5'd8,  5'd1,  5'd9,  1'b0, acc); chk("bp_acc3", int'(acc), 1);
      push_cmd(2'b11, 5'd31, 5'd1,  5'd30, 1'b0, acc); chk("bp_acc4", int'(acc), 1);
      push_cmd(2'b01, 5'd31, 5'd31, 5'd30, 1'b0, acc); chk("bp_acc5", int'(acc), 1);
      @(negedge clk);
      chk("bp_count",     int'(count),     4);
      chk("bp_cmd_ready", int'(cmd_ready), 0);
      chk("bp_res_valid", int'(res_valid), 1);
      chk("bp_res_data",  int'(res_data),  2);
      @(posedge clk);
      #1;
      push_cmd(2'b01, 5'd0, 5'd0, 5'd0, 1'b1, acc);
      chk("bp_sixth_refused", int'(acc), 0);
      @(negedge clk);
      chk("bp_hold_data",  int'(res_data),  2);
      chk("bp_hold_op",    int'(res_op),    1);
      chk("bp_hold_valid", int'(res_valid), 1);
      chk("bp_hold_count", int'(count),     4);
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("bp_drain_valid", int'(res_valid), 0);
      chk("bp_drain_count", int'(count),     0);
      chk("bp_drain_queue", exp_q.size(),    0);
      @(posedge clk);
      #1;

      // ---------------- flush mid-stream ----------------
      res_ready = 1'b0;
      push_cmd(2'b01, 5'd3, 5'd4, 5'd7,  1'b0, acc);
      push_cmd(2'b01, 5'd5, 5'd4, 5'd9,  1'b0, acc);
      push_cmd(2'b10, 5'd2, 5'd4, 5'd6,  1'b0, acc);
      push_cmd(2'b00, 5'd7, 5'd5, 5'd5,  1'b0, acc);
      @(negedge clk);
      chk("fl_pre_count", int'(count),     3);
      chk("fl_pre_valid", int'(res_valid), 1);
      @(posedge clk);
      #1;
      flush     = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      cmd_a     = 5'd9;
      cmd_b     = 5'd3;
      @(posedge clk);
      #1;
      flush     = 1'b0;
      cmd_valid = 1'b0;
      exp_q.delete();
      $display("flush applied with command op=3 a=9 b=3 offered");
      @(negedge clk);
      chk("fl_count",     int'(count),     0);
      chk("fl_res_valid", int'(res_valid), 0);
      chk("fl_res_data",  int'(res_data),  0);
      chk("fl_cmd_ready", int'(cmd_ready), 1);
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      push_cmd(2'b10, 5'd12, 5'd3, 5'd15, 1'b0, acc);
      repeat (3) @(posedge clk);
      #1;
      chk("fl_post_queue", exp_q.size(), 0);

      // ---------------- pointer wrap, res_ready toggling ----------------
      res_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               push_retry(wop[i], wa[i], wb[i], wr[i], wz[i]);
            end
         end
         begin
            repeat (30) begin
               res_ready = ~res_ready;
               @(posedge clk);
               #1;
            end
         end
      join
      res_ready = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !res_valid) done = 1'b1;
      end
      chk("wrap_all_results", int'(done), 1);
      chk("wrap_count", int'(count), 0);
      @(posedge clk);
      #1;

      // ---------------- reset mid-operation ----------------
      res_ready = 1'b0;
      push_cmd(2'b01, 5'd6, 5'd6, 5'd12, 1'b0, acc);
      push_cmd(2'b01, 5'd7, 5'd6, 5'd13, 1'b0, acc);
      push_cmd(2'b01, 5'd8, 5'd6, 5'd14, 1'b0, acc);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("mrst_count",     int'(count),     0);
      chk("mrst_res_valid", int'(res_valid), 0);
      chk("mrst_res_data",  int'(res_data),  0);
      chk("mrst_cmd_ready", int'(cmd_ready), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
